// File: rtl/regfile_dbg_port.sv
// Debug initiator for the core register file: streams a snapshot dump of
// x0..x(NREGS-1) over valid/ready and performs single host register writes.
module regfile_dbg_port #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int SKIP_X0 = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  input  logic            abort,
  output logic [AW-1:0]   rf_rs,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [AW-1:0]   out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, WRITE} state_t;

  localparam logic [AW-1:0] IDX_FIRST = (SKIP_X0 != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] IDX_LAST  = AW'(NREGS - 1);

  state_t          state, state_nx;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            last_q;
  logic            done_q;
  logic            dump_go, write_go, advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // abort outranks the SEND handshake; the word still counts as delivered
  always_comb begin
    state_nx = state;
    dump_go  = 1'b0;
    write_go = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = cmd_op ? WRITE : READ;
          dump_go  = !cmd_op;
          write_go = cmd_op;
        end
      end
      READ: state_nx = abort ? IDLE : SEND;
      SEND: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (out_ready) begin
          state_nx = last_q ? IDLE : READ;
          advance  = !last_q;
        end
      end
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      idx      <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      out_data <= '0;
      out_idx  <= '0;
      last_q   <= 1'b0;
    end else begin
      done_q <= (state != IDLE) && (state_nx == IDLE);
      if (dump_go)      idx <= IDX_FIRST;
      else if (advance) idx <= idx + 1'b1;
      if (write_go) begin
        wr_addr <= cmd_addr;
        wr_data <= cmd_wdata;
      end
      // captured word is a snapshot; later core writes cannot disturb it
      if (state == READ) begin
        out_data <= rf_rdata;
        out_idx  <= idx;
        last_q   <= (idx == IDX_LAST);
      end
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == SEND);
  assign out_last  = out_valid & last_q;
  assign rf_rs     = idx;
  assign rf_we     = (state == WRITE) && (wr_addr != '0);
  assign rf_rd     = wr_addr;
  assign rf_wdata  = wr_data;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Bench for regfile_dbg_port: two instances (x0 streamed / x0 skipped) on a modelled
// register file, checked every cycle against a transaction-level reference.
module tb_regfile_dbg_port;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk = 1'b0, rst_n = 1'b1;
  logic cmd_valid = 1'b0, cmd_op = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [XLEN-1:0] cmd_wdata = '0;
  logic            core_we = 1'b0;
  logic [AW-1:0]   core_addr = '0;
  logic [XLEN-1:0] core_data = '0;

  logic [1:0] cmd_ready, rf_we, out_valid, out_last, busy, done;
  logic [1:0][AW-1:0]   rf_rs, rf_rd, out_idx;
  logic [1:0][XLEN-1:0] rf_rdata, rf_wdata, out_data;

  logic [XLEN-1:0] rf    [2][NREGS];
  logic [XLEN-1:0] mregs [2][NREGS];

  int n_tests = 0, n_fail = 0, cyc = 0;

  // reference: pending write, read gap, word on offer, next index, held words
  bit              m_wr[2], m_gap[2], m_have[2], m_last[2], m_done[2];
  int              m_idx[2];
  logic [AW-1:0]   m_wa[2], m_oidx[2];
  logic [XLEN-1:0] m_wd[2], m_data[2];
  bit              loaded = 1'b0;

  int wcnt[2], lastcnt[2], wecnt[2];

  regfile_dbg_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .SKIP_X0(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .abort(abort),
    .rf_rs(rf_rs[0]), .rf_rdata(rf_rdata[0]), .rf_we(rf_we[0]), .rf_rd(rf_rd[0]),
    .rf_wdata(rf_wdata[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_data(out_data[0]), .out_idx(out_idx[0]), .out_last(out_last[0]),
    .busy(busy[0]), .done(done[0]));

  regfile_dbg_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .SKIP_X0(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .abort(abort),
    .rf_rs(rf_rs[1]), .rf_rdata(rf_rdata[1]), .rf_we(rf_we[1]), .rf_rd(rf_rd[1]),
    .rf_wdata(rf_wdata[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_data(out_data[1]), .out_idx(out_idx[1]), .out_last(out_last[1]),
    .busy(busy[1]), .done(done[1]));

  assign rf_rdata[0] = rf[0][rf_rs[0]];
  assign rf_rdata[1] = rf[1][rf_rs[1]];

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model and register-file environment
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin
        m_wr[j] = 0; m_gap[j] = 0; m_have[j] = 0; m_last[j] = 0; m_done[j] = 0;
        m_idx[j] = 0; m_wa[j] = '0; m_oidx[j] = '0; m_wd[j] = '0; m_data[j] = '0;
      end
      if (!loaded) begin
        for (int j = 0; j < 2; j++)
          for (int i = 0; i < NREGS; i++) begin
            rf[j][i]    <= XLEN'(32'hA500_0000 + i);
            mregs[j][i] = XLEN'(32'hA500_0000 + i);
          end
        loaded = 1'b1;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (rf_we[j]) rf[j][rf_rd[j]] <= rf_wdata[j];
        m_done[j] = 0;
        if (m_wr[j]) begin
          if (m_wa[j] != '0) mregs[j][m_wa[j]] = m_wd[j];
          m_wr[j] = 0; m_done[j] = 1;
        end else if (m_gap[j]) begin
          m_gap[j]  = 0;
          m_data[j] = mregs[j][m_idx[j]];
          m_oidx[j] = AW'(m_idx[j]);
          m_last[j] = (m_idx[j] == NREGS - 1);
          if (abort) m_done[j] = 1;
          else       m_have[j] = 1;
        end else if (m_have[j]) begin
          if (abort) begin
            m_have[j] = 0; m_done[j] = 1;
          end else if (out_ready) begin
            m_have[j] = 0;
            if (m_last[j]) m_done[j] = 1;
            else begin m_idx[j] = m_idx[j] + 1; m_gap[j] = 1; end
          end
        end else if (cmd_valid) begin
          if (cmd_op) begin m_wr[j] = 1; m_wa[j] = cmd_addr; m_wd[j] = cmd_wdata; end
          else begin m_idx[j] = j; m_gap[j] = 1; end
        end
      end
      if (core_we)
        for (int j = 0; j < 2; j++) begin
          rf[j][core_addr]    <= core_data;
          mregs[j][core_addr] = core_data;
        end
    end
  end

  always @(posedge clk)
    if (rst_n)
      for (int j = 0; j < 2; j++) begin
        if (out_valid[j] && out_ready) begin
          wcnt[j]++;
          if (out_last[j]) lastcnt[j]++;
        end
        if (rf_we[j]) wecnt[j]++;
      end

  function automatic logic [84:0] exp_vec(input int j);
    bit b;
    b = m_wr[j] | m_gap[j] | m_have[j];
    return {!b, m_wr[j] && (m_wa[j] != '0), m_have[j], m_have[j] && m_last[j], b,
            m_done[j], AW'(m_idx[j]), m_wa[j], m_oidx[j], m_wd[j], m_data[j]};
  endfunction

  function automatic logic [84:0] dut_vec(input int j);
    return {cmd_ready[j], rf_we[j], out_valid[j], out_last[j], busy[j], done[j],
            rf_rs[j], rf_rd[j], out_idx[j], rf_wdata[j], out_data[j]};
  endfunction

  task automatic check(input string name, input logic [84:0] got, input logic [84:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        n_tests++;
        if (dut_vec(j) !== exp_vec(j)) begin
          n_fail++;
          $display("FAIL outputs dut%0d cycle %0d: got %h want %h", j, cyc, dut_vec(j), exp_vec(j));
        end
      end
    end
  endtask

  // kind 0: done[j]; 1: word val on offer; 2: out_valid[j]; 3: both idle
  task automatic wait_for(input string name, input int kind, input int j, input int val);
    bit hit;
    hit = 0;
    for (int n = 0; n < 600 && !hit; n++) begin
      @(negedge clk);
      case (kind)
        0: hit = done[j];
        1: hit = out_valid[j] && (int'(out_idx[j]) == val);
        2: hit = out_valid[j];
        default: hit = (cmd_ready == 2'b11);
      endcase
    end
    if (!hit) begin
      n_tests++; n_fail++;
      $display("FAIL wait %s: got timeout want event", name);
    end
  endtask

  task automatic send_cmd(input bit op, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  int t0, b0, b1, l0, e0;
  bit hit;

  initial begin
    #1 rst_n = 1'b0;
    fork compare_loop(); join_none
    repeat (3) @(negedge clk);
    check("reset outputs dut0", dut_vec(0), {1'b1, 84'b0});
    check("reset outputs dut1", dut_vec(1), {1'b1, 84'b0});
    rst_n = 1'b1;
    @(negedge clk);

    // full dump, sink always ready
    out_ready = 1'b1; b0 = wcnt[0]; b1 = wcnt[1]; l0 = lastcnt[0]; t0 = cyc;
    send_cmd(0, '0, '0);
    wait_for("first word", 2, 0, 0);
    check("first valid latency", cyc - t0, 2);
    check("first word data", out_data[0], 32'hA500_0000);
    wait_for("dump done", 0, 0, 0);
    check("dump done latency", cyc - t0, 65);
    wait_for("idle", 3, 0, 0);
    check("dump words dut0", wcnt[0] - b0, 32);
    check("dump words dut1", wcnt[1] - b1, 31);
    check("out_last count", lastcnt[0] - l0, 1);

    // dump with sink ready one cycle in three
    out_ready = 1'b0; b0 = wcnt[0];
    send_cmd(0, '0, '0);
    hit = 0;
    for (int n = 0; n < 400 && !hit; n++) begin
      out_ready = (cyc % 3 == 0);
      @(negedge clk);
      hit = done[0];
    end
    check("stalled dump completes", hit, 1);
    out_ready = 1'b1;
    wait_for("idle", 3, 0, 0);
    check("stalled dump words", wcnt[0] - b0, 32);

    // writes, including the dropped x0 write
    e0 = wecnt[0];
    send_cmd(1, 5'd7, 32'hDEAD_BEEF);
    wait_for("write done", 0, 0, 0);
    check("x7 written", rf[0][7], 32'hDEAD_BEEF);
    check("write we cycles", wecnt[0] - e0, 1);
    e0 = wecnt[0];
    send_cmd(1, 5'd0, 32'hFFFF_FFFF);
    wait_for("x0 write done", 0, 0, 0);
    check("x0 unchanged", rf[0][0], 32'hA500_0000);
    check("x0 write we cycles", wecnt[0] - e0, 0);

    // abort while idx 5 is on offer, then a fresh dump
    send_cmd(0, '0, '0);
    wait_for("idx5", 1, 0, 5);
    abort = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("abort flags", {out_valid[0], done[0], cmd_ready[0]}, 3'b011);
    out_ready = 1'b1;
    send_cmd(0, '0, '0);
    wait_for("restart", 2, 0, 0);
    check("restart idx dut0", out_idx[0], 0);
    check("first idx dut1", out_idx[1], 1);
    wait_for("idle", 3, 0, 0);

    // core write to x3 after the skip-x0 instance has read it
    send_cmd(0, '0, '0);
    wait_for("dut1 idx3", 1, 1, 3);
    out_ready = 1'b0; core_we = 1'b1; core_addr = 5'd3; core_data = 32'h1234_5678;
    @(negedge clk);
    core_we = 1'b0;
    check("snapshot x3", out_data[1], 32'hA500_0003);
    repeat (3) @(negedge clk);
    check("snapshot x3 held", {out_valid[1], out_idx[1], out_data[1]}, {1'b1, 5'd3, 32'hA500_0003});
    out_ready = 1'b1;
    wait_for("idle", 3, 0, 0);

    // reset in the middle of a dump
    send_cmd(0, '0, '0);
    wait_for("idx12", 1, 0, 12);
    #2 rst_n = 1'b0;
    #1 check("mid-dump reset", dut_vec(0), {1'b1, 84'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b0 = wcnt[0];
    send_cmd(0, '0, '0);
    wait_for("post-reset done", 0, 0, 0);
    check("post-reset words", wcnt[0] - b0, 32);
    wait_for("idle", 3, 0, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom_range(0, NREGS - 1));
      cmd_wdata = $urandom;
      abort     = ($urandom_range(0, 63) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      core_we   = ($urandom_range(0, 7) == 0) && !m_wr[0] && !m_wr[1];
      core_addr = AW'($urandom_range(1, NREGS - 1));
      core_data = $urandom;
      @(negedge clk);
    end
    cmd_valid = 1'b0; abort = 1'b0; core_we = 1'b0; out_ready = 1'b1;
    wait_for("final idle", 3, 0, 0);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NREGS; i++)
        check($sformatf("regfile dut%0d x%0d", j, i), rf[j][i], mregs[j][i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
